// File: rtl/sig_dump_ctrl.sv
// End-of-test signature dumper: on a rising test-end flag, reads the signature
// window from instruction memory one word at a time and streams it to a sink.
module sig_dump_ctrl #(
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned RD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      end_flag_i,
  input  logic [31:0]      begin_sig_i,
  input  logic [31:0]      end_sig_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             dump_valid_o,
  output logic [31:0]      dump_data_o,
  output logic             dump_last_o,
  input  logic             dump_ready_i,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] dump_count_o
);

  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic               flag_q, flag_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        end_q, end_d;
  logic [31:0]        hold_q, hold_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               flag_hit;
  logic               is_last;
  logic               range_bad;
  logic [31:0]        span;

  assign flag_hit  = (end_flag_i == 32'h1);
  assign span      = end_sig_i - begin_sig_i;
  // span is only meaningful once begin<=end is known; the OR keeps that ordering harmless
  assign range_bad = (begin_sig_i[1:0] != 2'b00) || (end_sig_i[1:0] != 2'b00) ||
                     (begin_sig_i > end_sig_i) || ((span >> 2) > 32'(MAX_WORDS));
  assign is_last   = ((addr_q + 32'd4) == end_q);
  assign dump_count_o = count_q;

  always_comb begin
    state_d      = state_q;
    flag_d       = flag_hit;
    addr_d       = addr_q;
    end_d        = end_q;
    hold_d       = hold_q;
    count_d      = count_q;
    tmo_d        = tmo_q;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    dump_valid_o = 1'b0;
    dump_data_o  = '0;
    dump_last_o  = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flag_hit && !flag_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        addr_d  = begin_sig_i;
        end_d   = end_sig_i;
        count_d = '0;
        if (range_bad)                       state_d = S_ERR;
        else if (begin_sig_i == end_sig_i)   state_d = S_DONE;
        else                                 state_d = S_REQ;
      end
      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        tmo_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          hold_d  = mem_rdata_i;
          state_d = S_OUT;
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUT: begin
        dump_valid_o = 1'b1;
        dump_data_o  = hold_q;
        dump_last_o  = is_last;
        if (dump_ready_i) begin
          addr_d  = addr_q + 32'd4;
          count_d = count_q + 1'b1;
          state_d = is_last ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (!flag_hit) state_d = S_IDLE;
      end
      S_ERR: begin
        err_o = 1'b1;
        if (!flag_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      flag_q  <= 1'b0;
      addr_q  <= '0;
      end_q   <= '0;
      hold_q  <= '0;
      count_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Bench for sig_dump_ctrl: memory responder with random latency, random sink
// backpressure, and a transaction-level model of the expected signature stream.
module tb_sig_dump_ctrl;

  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 64;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   end_flag_i, begin_sig_i, end_sig_i;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          dump_valid_o;
  logic [31:0]   dump_data_o;
  logic          dump_last_o;
  logic          dump_ready_i;
  logic          done_o, err_o;
  logic [CW-1:0] dump_count_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  sig_dump_ctrl #(.MAX_WORDS(MAXW), .RD_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .end_flag_i(end_flag_i), .begin_sig_i(begin_sig_i),
    .end_sig_i(end_sig_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o), .dump_last_o(dump_last_o),
    .dump_ready_i(dump_ready_i), .done_o(done_o), .err_o(err_o), .dump_count_o(dump_count_o)
  );

  // memory contents: a fixed function of address, reseeded per dump
  logic [31:0] seed;
  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ seed;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // model / scoreboard state
  logic [31:0]  cur_begin;
  int unsigned  exp_words, hs_cnt, req_cnt, valid_cyc, stall;
  bit           outstanding, mon_en;
  logic [31:0]  got_q[$];

  // responder / sink control
  int unsigned  lat_max, ready_mode, cnt;
  bit           no_resp, spur_en, active;
  logic [31:0]  pend;

  initial begin
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; dump_ready_i = 1'b0;
    active = 1'b0; cnt = 0; pend = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (!rst) begin
        active = 1'b0;
      end else begin
        if (active) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memword(pend);
            active       = 1'b0;
          end
        end else if (spur_en && $urandom_range(3, 0) == 0) begin
          mem_rvalid_i = 1'b1;
        end
        if (mem_req_o) begin
          active = 1'b1;
          pend   = mem_addr_o;
          cnt    = no_resp ? 100000 : $urandom_range(lat_max, 1);
        end
      end
      case (ready_mode)
        0: dump_ready_i = 1'b1;
        1: dump_ready_i = ($urandom_range(3, 0) != 0);
        2: begin
          if (dump_valid_o && hs_cnt == 1 && stall < 10) begin
            dump_ready_i = 1'b0;
            stall++;
          end else begin
            dump_ready_i = 1'b1;
          end
        end
        default: dump_ready_i = 1'b0;
      endcase
    end
  end

  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req_o) begin
        chk("req_one_outstanding", outstanding, 0);
        chk("req_addr", mem_addr_o, cur_begin + req_cnt * 4);
        req_cnt++;
        outstanding = 1'b1;
      end
      if (pv && !pr) begin
        chk("stall_valid", dump_valid_o, 1);
        chk("stall_data", dump_data_o, pd);
        chk("stall_last", dump_last_o, pl);
      end
      if (dump_valid_o) valid_cyc++;
      if (dump_valid_o && dump_ready_i) begin
        chk("out_data", dump_data_o, memword(cur_begin + hs_cnt * 4));
        chk("out_last", dump_last_o, (hs_cnt + 1 == exp_words));
        chk("out_count", dump_count_o, hs_cnt);
        got_q.push_back(dump_data_o);
        hs_cnt++;
        outstanding = 1'b0;
      end
    end
    pv = dump_valid_o; pr = dump_ready_i; pd = dump_data_o; pl = dump_last_o;
  end

  task automatic idle_outputs(input string tag);
    chk({tag, "_ctl"}, {mem_req_o, dump_valid_o, dump_last_o, done_o, err_o}, 0);
    chk({tag, "_addr_data"}, {mem_addr_o, dump_data_o}, 0);
    chk({tag, "_count"}, dump_count_o, 0);
  endtask

  task automatic setup(input logic [31:0] b, input logic [31:0] e, input int unsigned lm,
                       input int unsigned rm, input bit nr, input int unsigned n);
    begin_sig_i = b; end_sig_i = e; cur_begin = b; exp_words = n;
    hs_cnt = 0; req_cnt = 0; valid_cyc = 0; outstanding = 1'b0; active = 1'b0;
    got_q.delete(); lat_max = lm; ready_mode = rm; no_resp = nr; spur_en = !nr;
    stall = 0; mon_en = 1'b1;
  endtask

  // rel_rst: the flag is already high under reset and reset is released here
  task automatic run(input logic [31:0] b, input logic [31:0] e, input int unsigned lm,
                     input int unsigned rm, input bit nr, input bit rel_rst, input string tag);
    bit          exp_err, seen;
    int unsigned n, budget, lat_i;
    exp_err = (b[1:0] != 2'b00) || (e[1:0] != 2'b00) || (b > e) || (((e - b) >> 2) > MAXW);
    n       = exp_err ? 0 : ((e - b) >> 2);
    @(posedge clk); #2;
    setup(b, e, lm, rm, nr, n);
    end_flag_i = 32'h1;
    if (rel_rst) rst = 1'b1;
    budget = 30 * n + 400;
    seen = 1'b0; lat_i = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o || err_o) begin seen = 1'b1; lat_i = i; end
    end
    chk({tag, "_finished"}, seen, 1);
    chk({tag, "_done"}, done_o, !(exp_err || nr));
    chk({tag, "_err"}, err_o, exp_err || nr);
    if (exp_err) begin
      chk({tag, "_err_latency_ok"}, lat_i <= 2, 1);
      chk({tag, "_no_req"}, req_cnt, 0);
      chk({tag, "_no_valid"}, valid_cyc, 0);
    end else if (nr) begin
      chk({tag, "_one_req"}, req_cnt, 1);
      chk({tag, "_no_valid"}, valid_cyc, 0);
      chk({tag, "_count"}, dump_count_o, 0);
    end else begin
      chk({tag, "_words"}, hs_cnt, n);
      chk({tag, "_reqs"}, req_cnt, n);
      chk({tag, "_count"}, dump_count_o, n);
    end
  endtask

  task automatic release_flag(input string tag);
    @(posedge clk); #2;
    case ($urandom_range(2, 0))
      0:       end_flag_i = 32'h0;
      1:       end_flag_i = 32'h2;
      default: end_flag_i = 32'hFFFF_FFFF;
    endcase
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_cleared"}, {done_o, err_o}, 0);
  endtask

  initial begin
    logic [31:0] b, e;
    int unsigned w, r;
    bit          seen;
    rst = 1'b0; end_flag_i = '0; begin_sig_i = '0; end_sig_i = '0;
    seed = 32'hDEAD_0000; mon_en = 1'b1; cur_begin = '0; exp_words = 0;
    lat_max = 1; ready_mode = 0; no_resp = 1'b0; spur_en = 1'b0;
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b1;

    run(32'h100, 32'h10C, 1, 0, 0, 0, "t1");
    chk("t1_nwords", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("t1_w0", got_q[0], 32'hDEAD_0100);
      chk("t1_w1", got_q[1], 32'hDEAD_0104);
      chk("t1_w2", got_q[2], 32'hDEAD_0108);
    end
    chk("t1_count_lit", dump_count_o, 3);
    release_flag("t1");

    run(32'h200, 32'h200, 1, 0, 0, 0, "t2");
    release_flag("t2");
    run(32'h102, 32'h110, 1, 0, 0, 0, "t3a");
    release_flag("t3a");
    run(32'h200, 32'h100, 1, 0, 0, 0, "t3b");
    release_flag("t3b");
    run(32'h100, 32'h112, 1, 0, 0, 0, "t3c");
    release_flag("t3c");

    seed = $urandom;
    run(32'h300, 32'h310, 3, 2, 0, 0, "t4");
    chk("t4_stalled", stall, 10);
    release_flag("t4");

    seed = $urandom;
    run(32'h400, 32'h408, 2, 1, 0, 0, "t6a");
    repeat (20) @(negedge clk);
    chk("t6_held_no_req", req_cnt, 2);
    chk("t6_held_done", done_o, 1);
    release_flag("t6a");
    seed = $urandom;
    run(32'h400, 32'h408, 2, 1, 0, 0, "t6b");
    release_flag("t6b");

    run(32'h0, 32'h1000, 1, 0, 0, 0, "max_ok");
    release_flag("max_ok");
    run(32'h0, 32'h1004, 1, 0, 0, 0, "max_over");
    release_flag("max_over");

    for (int k = 0; k < 16; k++) begin
      seed = $urandom;
      b = $urandom & 32'h0000_FFFC;
      w = $urandom_range(8, 0);
      e = b + w * 4;
      r = $urandom_range(9, 0);
      if (r == 0)      b[0] = 1'b1;
      else if (r == 1) e = b - 32'd4;
      else if (r == 2) e[1] = 1'b1;
      run(b, e, $urandom_range(4, 1), $urandom_range(1, 0), 0, 0, "rnd");
      release_flag("rnd");
    end

    run(32'h500, 32'h510, 1, 0, 1, 0, "t5_tmo");
    release_flag("t5_tmo");

    // reset while a word is being offered
    @(posedge clk); #2;
    setup(32'h600, 32'h610, 1, 3, 0, 4);
    spur_en = 1'b0;
    end_flag_i = 32'h1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dump_valid_o) seen = 1'b1;
    end
    chk("t5_rst_reached_out", seen, 1);
    @(posedge clk); #2;
    mon_en = 1'b0; rst = 1'b0; end_flag_i = 32'h0;
    @(posedge clk);
    @(negedge clk);
    idle_outputs("t5_rst_mid_out");

    @(posedge clk); #2;
    end_flag_i = 32'h1;
    repeat (3) @(negedge clk);
    seed = $urandom;
    run(32'h700, 32'h708, 1, 0, 0, 1, "lvl_from_reset");
    release_flag("lvl_from_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
